audio_sample_fifo: RTL and testbench
====================================

# audio_sample_fifo

Stereo sample buffer between the synth mixer output and the left-justified 24-bit serial transmitter. It accepts 24-bit samples tagged left/right from the mixer and enforces strict L/R alternation. It stores them as 32-bit words and serves the transmitter through a read-request/empty interface, returning data one cycle after each request. It also reports fill level, overflow, L/R sequencing errors and transmitter underruns.

## Interface
- ADDR_W, 4, log2 of FIFO depth; depth = 2^ADDR_W words (default 16)
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- wr_req  in  1  mixer write strobe, one sample per asserted cycle
- wr_sample  in  24  signed sample
- wr_chan  in  1  channel tag: 0 = left, 1 = right
- wr_full  out  1  FIFO full; writes dropped while high
- fifo_rdreq  in  1  transmitter read request
- fifo_empty  out  1  FIFO empty
- fifo_data  out  32  read word {sample[23:0], 7'b0, chan}, registered
- level  out  ADDR_W+1  words currently stored
- err_clear  in  1  clears overflow, seq_err, underrun_cnt
- overflow  out  1  sticky: write attempted while full
- seq_err  out  1  sticky: write with unexpected channel tag
- underrun_cnt  out  8  saturating count of reads while empty

## Operation
- Storage: 2^ADDR_W x 32 array. wr_ptr/rd_ptr are ADDR_W+1 bits and wrap naturally. level = wr_ptr - rd_ptr (modulo 2^(ADDR_W+1)).
- fifo_empty = (level == 0); wr_full = (level == 2^ADDR_W). Both are decoded from registered pointers only, with no combinational path from inputs.
- exp_chan register starts at 0 (left).
- Write accepted iff wr_req & !wr_full & (wr_chan == exp_chan).
  - Stores {wr_sample, 7'b0, wr_chan} at wr_ptr.
  - wr_ptr increments and exp_chan toggles.
- wr_req & wr_full: word dropped, overflow <= 1, exp_chan unchanged. Full takes precedence over the channel check, so seq_err is not set.
- wr_req & !wr_full & wrong tag: word dropped, seq_err <= 1, exp_chan unchanged. The mixer resynchronises by sending the expected channel.
- Read with fifo_rdreq & !fifo_empty: fifo_data <= mem[rd_ptr], rd_ptr increments.
- Read with fifo_rdreq & fifo_empty: fifo_data <= 0, underrun_cnt += 1, saturating at 255.
- No fifo_rdreq: fifo_data holds its value.
- err_clear: overflow, seq_err and underrun_cnt are cleared next edge. If an error event occurs in the same cycle, the event wins: the flag is set, or the counter becomes 1.

## Timing
- Reset values:
  - wr_ptr = rd_ptr = 0, level 0
  - fifo_empty 1, wr_full 0, fifo_data 0
  - overflow 0, seq_err 0, underrun_cnt 0
  - exp_chan 0
- Read latency: fifo_data is valid on the edge after the cycle fifo_rdreq is sampled (1 cycle).
- Write-to-visible: a word accepted at edge N clears fifo_empty after edge N and can be requested in cycle N+1. Its data appears after edge N+2.
- There is no write-to-read bypass. On simultaneous write and read while empty, the write is accepted and the read counts as an underrun returning 0.
- Simultaneous write and read while full: the read proceeds, and the write is still rejected (overflow set), because full is evaluated on pre-edge state.
- Simultaneous accepted write and valid read: level unchanged.
- Back-to-back reads every cycle are supported at full rate. Back-to-back writes are supported at full rate.
- Asynchronous reset mid-operation discards all contents immediately. Outputs take reset values without waiting for a clock edge.

## Test plan
- Reset, then write L=0x000400, R=0x000401 on consecutive cycles, then pulse fifo_rdreq twice -> level goes 0→1→2. fifo_data = 0x00040000 then 0x00040101, each one cycle after its request. fifo_empty = 1 afterwards.
- Write 16 alternating L/R words, then a 17th (L) -> wr_full = 1 at level 16, 17th dropped, overflow = 1. Read-back order intact. The next accepted tag is still L.
- Write L, then L again, then R -> second L dropped, seq_err = 1, level = 2. Stored channels read back 0 then 1.
- Hold fifo_rdreq for 300 cycles with the FIFO empty -> fifo_data = 0 throughout, underrun_cnt saturates at 255. err_clear -> 0.
- Level 16, assert wr_req and fifo_rdreq in the same cycle -> level 15, overflow = 1. Empty FIFO with simultaneous write and read -> level 1, underrun_cnt +1, fifo_data = 0.
- Assert reset_n low mid-stream at level 7 -> immediately fifo_empty = 1, level = 0, fifo_data = 0, flags cleared. The next write must be L.

Source files
------------

// File: rtl/audio_sample_fifo_if.sv
// audio_sample_fifo_if -- handshake bundle between the mixer/transmitter side
// (master) and the stereo sample FIFO (slave).
//   wr_req/wr_sample/wr_chan : mixer write strobe, 24-bit sample, L/R tag
//   wr_full                  : FIFO full, writes dropped while high
//   fifo_rdreq               : transmitter read request
//   fifo_empty               : FIFO empty
//   fifo_data                : registered read word {sample, 7'b0, chan}
interface audio_sample_fifo_if;
  logic        wr_req;
  logic [23:0] wr_sample;
  logic        wr_chan;
  logic        wr_full;
  logic        fifo_rdreq;
  logic        fifo_empty;
  logic [31:0] fifo_data;

  modport master (
    output wr_req, wr_sample, wr_chan, fifo_rdreq,
    input  wr_full, fifo_empty, fifo_data
  );

  modport slave (
    input  wr_req, wr_sample, wr_chan, fifo_rdreq,
    output wr_full, fifo_empty, fifo_data
  );
endinterface

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo -- stereo sample buffer between mixer and serial
// transmitter. Enforces strict L/R alternation on writes, stores 32-bit words,
// returns read data one cycle after each request, and reports fill level,
// overflow, sequencing errors and transmitter underruns.
//   clk          : system clock, rising edge
//   reset_n      : asynchronous active-low reset
//   bus          : write/read handshake (slave modport)
//   level        : words currently stored
//   err_clear    : clears overflow, seq_err, underrun_cnt
//   overflow     : sticky, write attempted while full
//   seq_err      : sticky, write with unexpected channel tag
//   underrun_cnt : saturating count of reads while empty
module audio_sample_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  audio_sample_fifo_if.slave bus,
  output logic [ADDR_W:0]   level,
  input  logic              err_clear,
  output logic              overflow,
  output logic              seq_err,
  output logic [7:0]        underrun_cnt
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]     mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            exp_chan;

  logic wr_accept;
  logic wr_bad_tag;
  logic rd_valid;
  logic rd_under;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign level          = wr_ptr - rd_ptr;
  assign bus.fifo_empty = (level == '0);
  assign bus.wr_full    = (level == (ADDR_W + 1)'(DEPTH));

  // Full is checked before the tag, so a write while full never flags seq_err.
  assign wr_accept  = bus.wr_req & ~bus.wr_full & (bus.wr_chan == exp_chan);
  assign wr_bad_tag = bus.wr_req & ~bus.wr_full & (bus.wr_chan != exp_chan);
  assign rd_valid   = bus.fifo_rdreq & ~bus.fifo_empty;
  assign rd_under   = bus.fifo_rdreq & bus.fifo_empty;

  // NOTE: the storage array has no reset; pointers define validity, and
  // leaving it unreset lets synthesis map it onto RAM.
  always_ff @(posedge clk) begin
    if (wr_accept)
      mem[wr_ptr[ADDR_W-1:0]] <= {bus.wr_sample, 7'b0, bus.wr_chan};
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values (full/empty are evaluated on pre-edge pointers).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      exp_chan      <= 1'b0;
      bus.fifo_data <= '0;
      overflow      <= 1'b0;
      seq_err       <= 1'b0;
      underrun_cnt  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr   <= wr_ptr + 1'b1;
        exp_chan <= ~exp_chan;
      end

      if (rd_valid) begin
        bus.fifo_data <= mem[rd_ptr[ADDR_W-1:0]];
        rd_ptr        <= rd_ptr + 1'b1;
      end else if (rd_under) begin
        bus.fifo_data <= '0;
      end

      // Error events take priority over err_clear in the same cycle.
      if (bus.wr_req && bus.wr_full) overflow <= 1'b1;
      else if (err_clear)            overflow <= 1'b0;

      if (wr_bad_tag)     seq_err <= 1'b1;
      else if (err_clear) seq_err <= 1'b0;

      if (rd_under) begin
        if (err_clear)                  underrun_cnt <= 8'd1;
        else if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
      end else if (err_clear) begin
        underrun_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_audio_sample_fifo.sv
module tb_audio_sample_fifo;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       err_clear = 1'b0;
  logic [4:0] level;
  logic       overflow;
  logic       seq_err;
  logic [7:0] underrun_cnt;
  int         vectors = 0;
  int         miscompares = 0;

  audio_sample_fifo_if bus ();

  audio_sample_fifo #(.ADDR_W(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus.slave),
    .level        (level),
    .err_clear    (err_clear),
    .overflow     (overflow),
    .seq_err      (seq_err),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  // Advance one edge, then settle so outputs are sampled away from it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_req     = 1'b0;
    bus.wr_sample  = '0;
    bus.wr_chan    = 1'b0;
    bus.fifo_rdreq = 1'b0;
    err_clear      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();
  endtask

  task automatic write_word(input logic chan, input logic [23:0] sample);
    bus.wr_req    = 1'b1;
    bus.wr_chan   = chan;
    bus.wr_sample = sample;
    cycle();
    bus.wr_req    = 1'b0;
  endtask

  task automatic read_word();
    bus.fifo_rdreq = 1'b1;
    cycle();
    bus.fifo_rdreq = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({bus.fifo_empty, bus.wr_full, level} !== {1'b1, 1'b0, 5'd0}) begin
      $display("FAIL reset_ptrs: got empty=%b full=%b level=%0d want 1 0 0", bus.fifo_empty, bus.wr_full, level);
      miscompares++;
    end
    vectors++;
    if ({bus.fifo_data, overflow, seq_err, underrun_cnt} !== 42'd0) begin
      $display("FAIL reset_outs: got data=%h ovf=%b seq=%b und=%0d want all 0", bus.fifo_data, overflow, seq_err, underrun_cnt);
      miscompares++;
    end
  endtask

  task automatic test_basic();
    do_reset();
    write_word(1'b0, 24'h000400);
    vectors++;
    if (level !== 5'd1) begin $display("FAIL basic_lvl1: got %0d want 1", level); miscompares++; end
    write_word(1'b1, 24'h000401);
    vectors++;
    if (level !== 5'd2) begin $display("FAIL basic_lvl2: got %0d want 2", level); miscompares++; end
    read_word();
    vectors++;
    if (bus.fifo_data !== 32'h00040000) begin $display("FAIL basic_rd0: got %h want 00040000", bus.fifo_data); miscompares++; end
    read_word();
    vectors++;
    if (bus.fifo_data !== 32'h00040101) begin $display("FAIL basic_rd1: got %h want 00040101", bus.fifo_data); miscompares++; end
    vectors++;
    if (bus.fifo_empty !== 1'b1) begin $display("FAIL basic_empty: got %b want 1", bus.fifo_empty); miscompares++; end
  endtask

  task automatic test_full();
    logic [23:0] s;
    int          bad;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      s = 24'(i + 1);
      write_word(s[0] ^ 1'b1, s);   // sample i+1 tagged with i[0]
    end
    vectors++;
    if ({bus.wr_full, level} !== {1'b1, 5'd16}) begin
      $display("FAIL full_flag: got full=%b level=%0d want 1 16", bus.wr_full, level);
      miscompares++;
    end
    write_word(1'b0, 24'hABCDEF);
    vectors++;
    if ({level, overflow, seq_err} !== {5'd16, 1'b1, 1'b0}) begin
      $display("FAIL full_drop: got level=%0d ovf=%b seq=%b want 16 1 0", level, overflow, seq_err);
      miscompares++;
    end
    bad = 0;
    bus.fifo_rdreq = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      s = 24'(i + 1);
      if (bus.fifo_data !== {s, 7'b0, s[0] ^ 1'b1}) begin
        $display("FAIL full_order[%0d]: got %h want %h", i, bus.fifo_data, {s, 7'b0, s[0] ^ 1'b1});
        bad++;
      end
    end
    bus.fifo_rdreq = 1'b0;
    vectors++;
    if (bad != 0) miscompares++;
    write_word(1'b1, 24'h000055);   // R must still be rejected
    write_word(1'b0, 24'h000066);
    vectors++;
    if ({level, seq_err} !== {5'd1, 1'b1}) begin
      $display("FAIL full_next_l: got level=%0d seq=%b want 1 1", level, seq_err);
      miscompares++;
    end
    err_clear = 1'b1;
    cycle();
    err_clear = 1'b0;
    vectors++;
    if ({overflow, seq_err} !== 2'b00) begin
      $display("FAIL full_clear: got ovf=%b seq=%b want 0 0", overflow, seq_err);
      miscompares++;
    end
  endtask

  task automatic test_seq();
    do_reset();
    write_word(1'b0, 24'h111111);
    write_word(1'b0, 24'h222222);
    vectors++;
    if ({seq_err, level} !== {1'b1, 5'd1}) begin
      $display("FAIL seq_flag: got seq=%b level=%0d want 1 1", seq_err, level);
      miscompares++;
    end
    write_word(1'b1, 24'h333333);
    vectors++;
    if (level !== 5'd2) begin $display("FAIL seq_lvl: got %0d want 2", level); miscompares++; end
    read_word();
    vectors++;
    if (bus.fifo_data !== 32'h11111100) begin $display("FAIL seq_rd0: got %h want 11111100", bus.fifo_data); miscompares++; end
    read_word();
    vectors++;
    if (bus.fifo_data !== 32'h33333301) begin $display("FAIL seq_rd1: got %h want 33333301", bus.fifo_data); miscompares++; end
  endtask

  task automatic test_underrun();
    int bad;
    int want;
    do_reset();
    bad = 0;
    bus.fifo_rdreq = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cycle();
      want = (i + 1 > 255) ? 255 : i + 1;
      if (bus.fifo_data !== 32'd0 || underrun_cnt !== 8'(want)) begin
        if (bad < 4)
          $display("FAIL und_step[%0d]: got data=%h cnt=%0d want 0 %0d", i, bus.fifo_data, underrun_cnt, want);
        bad++;
      end
    end
    vectors++;
    if (bad != 0) miscompares++;
    vectors++;
    if (underrun_cnt !== 8'd255) begin $display("FAIL und_sat: got %0d want 255", underrun_cnt); miscompares++; end
    bus.fifo_rdreq = 1'b0;
    err_clear = 1'b1;
    cycle();
    vectors++;
    if (underrun_cnt !== 8'd0) begin $display("FAIL und_clear: got %0d want 0", underrun_cnt); miscompares++; end
    bus.fifo_rdreq = 1'b1;   // clear and event together: event wins
    cycle();
    bus.fifo_rdreq = 1'b0;
    err_clear = 1'b0;
    vectors++;
    if (underrun_cnt !== 8'd1) begin $display("FAIL und_clr_evt: got %0d want 1", underrun_cnt); miscompares++; end
  endtask

  task automatic test_simultaneous();
    logic [23:0] s;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      s = 24'(16'h0100 + i);
      write_word(1'(i % 2), s);
    end
    bus.wr_req = 1'b1; bus.wr_chan = 1'b0; bus.wr_sample = 24'h777777;
    bus.fifo_rdreq = 1'b1;
    cycle();
    idle_inputs();
    vectors++;
    if ({level, overflow, bus.fifo_data} !== {5'd15, 1'b1, 32'h00010000}) begin
      $display("FAIL simul_full: got level=%0d ovf=%b data=%h want 15 1 00010000", level, overflow, bus.fifo_data);
      miscompares++;
    end
    do_reset();
    write_word(1'b0, 24'h0000AA);
    write_word(1'b1, 24'h0000AB);
    read_word();
    read_word();
    vectors++;
    if (bus.fifo_data !== 32'h0000AB01) begin $display("FAIL simul_pre: got %h want 0000ab01", bus.fifo_data); miscompares++; end
    bus.wr_req = 1'b1; bus.wr_chan = 1'b0; bus.wr_sample = 24'h000123;
    bus.fifo_rdreq = 1'b1;
    cycle();
    idle_inputs();
    vectors++;
    if ({level, underrun_cnt, bus.fifo_data} !== {5'd1, 8'd1, 32'd0}) begin
      $display("FAIL simul_empty: got level=%0d und=%0d data=%h want 1 1 0", level, underrun_cnt, bus.fifo_data);
      miscompares++;
    end
    read_word();
    vectors++;
    if (bus.fifo_data !== 32'h00012300) begin $display("FAIL simul_rd: got %h want 00012300", bus.fifo_data); miscompares++; end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 8; i++) write_word(1'(i % 2), 24'(i + 8'h40));
    read_word();
    write_word(1'b1, 24'h0000EE);   // expected L: sets seq_err
    vectors++;
    if ({level, seq_err, bus.fifo_data} !== {5'd7, 1'b1, 32'h00004000}) begin
      $display("FAIL arst_pre: got level=%0d seq=%b data=%h want 7 1 00004000", level, seq_err, bus.fifo_data);
      miscompares++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus.fifo_empty, level, bus.fifo_data, seq_err, overflow, underrun_cnt} !== {1'b1, 5'd0, 32'd0, 1'b0, 1'b0, 8'd0}) begin
      $display("FAIL arst_now: got empty=%b level=%0d data=%h seq=%b want 1 0 0 0", bus.fifo_empty, level, bus.fifo_data, seq_err);
      miscompares++;
    end
    cycle();
    reset_n = 1'b1;
    cycle();
    write_word(1'b1, 24'h000011);
    vectors++;
    if ({level, seq_err} !== {5'd0, 1'b1}) begin
      $display("FAIL arst_r_drop: got level=%0d seq=%b want 0 1", level, seq_err);
      miscompares++;
    end
    write_word(1'b0, 24'h000022);
    vectors++;
    if (level !== 5'd1) begin $display("FAIL arst_l_ok: got %0d want 1", level); miscompares++; end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_full();
    test_seq();
    test_underrun();
    test_simultaneous();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
